// File: rtl/decode_cycle_if.sv
// Decode-stage bus: IF/ID inputs, writeback port, flush, and the ID/EX outputs.
interface decode_cycle_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic [DATA_WIDTH-1:0] InstrD;
    logic [DATA_WIDTH-1:0] PCD;
    logic [DATA_WIDTH-1:0] PCPlus4D;
    logic                  RegWriteW;
    logic [REG_ADDR_W-1:0] RDW;
    logic [DATA_WIDTH-1:0] ResultW;
    logic                  FlushE;

    logic [REG_ADDR_W-1:0] Rs1D;
    logic [REG_ADDR_W-1:0] Rs2D;
    logic                  RegWriteE;
    logic                  MemWriteE;
    logic                  JumpE;
    logic                  BranchE;
    logic                  ALUSrcE;
    logic                  ResultSrcE;
    logic [2:0]            ALUControlE;
    logic [DATA_WIDTH-1:0] RD1E;
    logic [DATA_WIDTH-1:0] RD2E;
    logic [DATA_WIDTH-1:0] ImmExtE;
    logic [DATA_WIDTH-1:0] PCE;
    logic [DATA_WIDTH-1:0] PCPlus4E;
    logic [REG_ADDR_W-1:0] RdE;
    logic [REG_ADDR_W-1:0] Rs1E;
    logic [REG_ADDR_W-1:0] Rs2E;
    logic                  IllegalE;

    // Upstream side: fetch, writeback and hazard unit drive the decode inputs.
    modport master (
        output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        input  Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               RdE, Rs1E, Rs2E, IllegalE
    );

    // Decode stage itself.
    modport slave (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        output Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               RdE, Rs1E, Rs2E, IllegalE
    );
endinterface

// File: rtl/decode_cycle.sv
// RV32I decode stage: register file, main/ALU decoders, immediate extender and
// the ID/EX pipeline register. Only DATA_WIDTH=32 is supported.
module decode_cycle #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    decode_cycle_if.slave bus
);
    localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic                  w_funct7b5;
    logic [REG_ADDR_W-1:0] w_rs1;
    logic [REG_ADDR_W-1:0] w_rs2;
    logic [REG_ADDR_W-1:0] w_rd;
    logic                  w_wr_active;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    logic      w_reg_write_raw, w_mem_write_raw, w_branch_raw, w_jump_raw;
    logic      w_alu_src, w_result_src, w_op_illegal, w_funct_illegal, w_illegal;
    imm_src_t  w_imm_src;
    alu_op_t   w_alu_op;
    alu_ctrl_t w_alu_control;
    logic [DATA_WIDTH-1:0] w_imm_ext;

    logic                  r_reg_write, r_mem_write, r_jump, r_branch;
    logic                  r_alu_src, r_result_src, r_illegal;
    logic [2:0]            r_alu_control;
    logic [DATA_WIDTH-1:0] r_rd1, r_rd2, r_imm_ext, r_pc, r_pc_plus4;
    logic [REG_ADDR_W-1:0] r_rd, r_rs1, r_rs2;

    assign w_opcode   = bus.InstrD[6:0];
    assign w_funct3   = bus.InstrD[14:12];
    assign w_funct7b5 = bus.InstrD[30];
    assign w_rs1      = bus.InstrD[19:15];
    assign w_rs2      = bus.InstrD[24:20];
    assign w_rd       = bus.InstrD[11:7];

    // Source indices for the hazard unit; held at 0 while in reset.
    assign bus.Rs1D = rst ? w_rs1 : '0;
    assign bus.Rs2D = rst ? w_rs2 : '0;

    assign w_wr_active = bus.RegWriteW && (bus.RDW != '0);

    // Register file write port; x0 is never written so it always reads 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_active) begin
            r_regs[bus.RDW] <= bus.ResultW;
        end
    end

    // Combinational reads with write-through of the same-cycle writeback.
    always_comb begin
        w_rd1 = r_regs[w_rs1];
        w_rd2 = r_regs[w_rs2];
        if (w_wr_active && (bus.RDW == w_rs1)) w_rd1 = bus.ResultW;
        if (w_wr_active && (bus.RDW == w_rs2)) w_rd2 = bus.ResultW;
    end

    // Main decoder: opcode to control signals; unknown opcodes are illegal.
    always_comb begin
        w_reg_write_raw = 1'b0;
        w_mem_write_raw = 1'b0;
        w_branch_raw    = 1'b0;
        w_jump_raw      = 1'b0;
        w_alu_src       = 1'b0;
        w_result_src    = 1'b0;
        w_imm_src       = IMM_I;
        w_alu_op        = ALUOP_ADD;
        w_op_illegal    = 1'b0;
        case (w_opcode)
            7'b0000011: begin // lw
                w_reg_write_raw = 1'b1;
                w_alu_src       = 1'b1;
                w_result_src    = 1'b1;
            end
            7'b0100011: begin // sw
                w_imm_src       = IMM_S;
                w_alu_src       = 1'b1;
                w_mem_write_raw = 1'b1;
            end
            7'b0110011: begin // R-type
                w_reg_write_raw = 1'b1;
                w_alu_op        = ALUOP_FUNCT;
            end
            7'b0010011: begin // I-type ALU
                w_reg_write_raw = 1'b1;
                w_alu_src       = 1'b1;
                w_alu_op        = ALUOP_FUNCT;
            end
            7'b1100011: begin // beq
                w_imm_src    = IMM_B;
                w_branch_raw = 1'b1;
                w_alu_op     = ALUOP_SUB;
            end
            7'b1101111: begin // jal
                w_reg_write_raw = 1'b1;
                w_imm_src       = IMM_J;
                w_jump_raw      = 1'b1;
            end
            default: w_op_illegal = 1'b1;
        endcase
    end

    // ALU decoder: funct3/funct7 select the operation for ALU-class opcodes.
    always_comb begin
        w_alu_control   = ALU_ADD;
        w_funct_illegal = 1'b0;
        case (w_alu_op)
            ALUOP_ADD: w_alu_control = ALU_ADD;
            ALUOP_SUB: w_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (w_funct3)
                    3'b000:  w_alu_control = (w_opcode == 7'b0110011 && w_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  w_alu_control = ALU_SLT;
                    3'b110:  w_alu_control = ALU_OR;
                    3'b111:  w_alu_control = ALU_AND;
                    default: w_funct_illegal = 1'b1;
                endcase
            end
            default: w_alu_control = ALU_ADD;
        endcase
    end

    assign w_illegal = w_op_illegal | w_funct_illegal;

    // Immediate extender, sign-extended from the instruction MSB.
    always_comb begin
        w_imm_ext = '0;
        case (w_imm_src)
            IMM_I: w_imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
            IMM_S: w_imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
            IMM_B: w_imm_ext = {{19{bus.InstrD[31]}}, bus.InstrD[31], bus.InstrD[7],
                                bus.InstrD[30:25], bus.InstrD[11:8], 1'b0};
            IMM_J: w_imm_ext = {{11{bus.InstrD[31]}}, bus.InstrD[31], bus.InstrD[19:12],
                                bus.InstrD[20], bus.InstrD[30:21], 1'b0};
        endcase
    end

    // ID/EX register: captures decode results, or a bubble on flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || bus.FlushE) begin
            r_reg_write   <= 1'b0;
            r_mem_write   <= 1'b0;
            r_jump        <= 1'b0;
            r_branch      <= 1'b0;
            r_alu_src     <= 1'b0;
            r_result_src  <= 1'b0;
            r_alu_control <= '0;
            r_illegal     <= 1'b0;
            r_rd1         <= '0;
            r_rd2         <= '0;
            r_imm_ext     <= '0;
            r_pc          <= '0;
            r_pc_plus4    <= '0;
            r_rd          <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
        end else begin
            // Illegal instructions become nops: no register, memory or PC side effects.
            r_reg_write   <= w_reg_write_raw & ~w_illegal;
            r_mem_write   <= w_mem_write_raw & ~w_illegal;
            r_jump        <= w_jump_raw & ~w_illegal;
            r_branch      <= w_branch_raw & ~w_illegal;
            r_alu_src     <= w_alu_src;
            r_result_src  <= w_result_src;
            r_alu_control <= w_alu_control;
            r_illegal     <= w_illegal;
            r_rd1         <= w_rd1;
            r_rd2         <= w_rd2;
            r_imm_ext     <= w_imm_ext;
            r_pc          <= bus.PCD;
            r_pc_plus4    <= bus.PCPlus4D;
            r_rd          <= w_rd;
            r_rs1         <= w_rs1;
            r_rs2         <= w_rs2;
        end
    end

    assign bus.RegWriteE   = r_reg_write;
    assign bus.MemWriteE   = r_mem_write;
    assign bus.JumpE       = r_jump;
    assign bus.BranchE     = r_branch;
    assign bus.ALUSrcE     = r_alu_src;
    assign bus.ResultSrcE  = r_result_src;
    assign bus.ALUControlE = r_alu_control;
    assign bus.IllegalE    = r_illegal;
    assign bus.RD1E        = r_rd1;
    assign bus.RD2E        = r_rd2;
    assign bus.ImmExtE     = r_imm_ext;
    assign bus.PCE         = r_pc;
    assign bus.PCPlus4E    = r_pc_plus4;
    assign bus.RdE         = r_rd;
    assign bus.Rs1E        = r_rs1;
    assign bus.Rs2E        = r_rs2;
endmodule

// File: tb/tb_decode_cycle.sv
// Directed-vector bench for decode_cycle: decode table plus reset, write-through
// and flush sequences.
module tb_decode_cycle;
    logic clk;
    logic rst;

    decode_cycle_if #(.DATA_WIDTH(32), .REG_ADDR_W(5)) bus ();

    decode_cycle #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl bit order: RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc, ALUControl[2:0], Illegal
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [9:0]  ctrl;
        logic [4:0]  rd;
        logic        chk_imm;
        logic [31:0] imm;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    int n_vec;
    int n_bad;

    logic [9:0]   w_act_ctrl;
    logic [184:0] w_all_e;
    logic [9:0]   w_all_d;

    assign w_act_ctrl = {bus.RegWriteE, bus.MemWriteE, bus.JumpE, bus.BranchE, bus.ALUSrcE,
                         bus.ResultSrcE, bus.ALUControlE, bus.IllegalE};
    assign w_all_e = {w_act_ctrl, bus.RD1E, bus.RD2E, bus.ImmExtE, bus.PCE, bus.PCPlus4E,
                      bus.RdE, bus.Rs1E, bus.Rs2E};
    assign w_all_d = {bus.Rs1D, bus.Rs2D};

    function automatic vec_t mk(string name, logic [31:0] instr, logic [31:0] pcd,
                                logic [9:0] ctrl, logic [4:0] rd, logic chk_imm,
                                logic [31:0] imm);
        vec_t v;
        v.name = name; v.instr = instr; v.pcd = pcd; v.ctrl = ctrl;
        v.rd = rd; v.chk_imm = chk_imm; v.imm = imm;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        v;
        logic [31:0] ins;

        n_vec = 0;
        n_bad = 0;

        vecs[0]  = mk("addi",     32'h00500093, 32'h10, 10'b1000_10_000_0, 5'd1,  1'b1, 32'd5);
        vecs[1]  = mk("sw",       32'h0020A423, 32'h20, 10'b0100_10_000_0, 5'd8,  1'b1, 32'd8);
        vecs[2]  = mk("beq",      32'hFE208EE3, 32'h24, 10'b0001_00_001_0, 5'd29, 1'b1, 32'hFFFFFFFC);
        vecs[3]  = mk("lw",       32'hFFF02283, 32'h28, 10'b1000_11_000_0, 5'd5,  1'b1, 32'hFFFFFFFF);
        vecs[4]  = mk("add",      32'h002081B3, 32'h2C, 10'b1000_00_000_0, 5'd3,  1'b0, 32'h0);
        vecs[5]  = mk("sub",      32'h40208133, 32'h30, 10'b1000_00_001_0, 5'd2,  1'b0, 32'h0);
        vecs[6]  = mk("jal",      32'h008000EF, 32'h34, 10'b1010_00_000_0, 5'd1,  1'b1, 32'd8);
        vecs[7]  = mk("slti",     32'hFFF0A213, 32'h38, 10'b1000_10_101_0, 5'd4,  1'b1, 32'hFFFFFFFF);
        vecs[8]  = mk("or",       32'h0020E2B3, 32'h3C, 10'b1000_00_011_0, 5'd5,  1'b0, 32'h0);
        vecs[9]  = mk("andi",     32'h00F0F313, 32'h40, 10'b1000_10_010_0, 5'd6,  1'b1, 32'hF);
        vecs[10] = mk("ill_op7f", 32'h0000007F, 32'h44, 10'b0000_00_000_1, 5'd0,  1'b0, 32'h0);
        vecs[11] = mk("ill_zero", 32'h00000000, 32'h48, 10'b0000_00_000_1, 5'd0,  1'b0, 32'h0);
        vecs[12] = mk("ill_xor",  32'h0020C233, 32'h4C, 10'b0000_00_000_1, 5'd4,  1'b0, 32'h0);

        // Reset held with a valid instruction present: everything stays 0.
        rst           = 1'b0;
        bus.InstrD    = 32'h002081B3;
        bus.PCD       = 32'h8;
        bus.PCPlus4D  = 32'hC;
        bus.RegWriteW = 1'b0;
        bus.RDW       = '0;
        bus.ResultW   = '0;
        bus.FlushE    = 1'b0;
        repeat (3) tick();
        check("reset_hold_E", 256'(w_all_e), 256'(0));
        check("reset_hold_D", 256'(w_all_d), 256'(0));

        rst = 1'b1;
        tick();
        check("post_reset_ctrl", 256'(w_act_ctrl), 256'(10'b1000_00_000_0));
        check("post_reset_rd_pc", 256'({bus.RdE, bus.PCE, bus.PCPlus4E}), 256'({5'd3, 32'h8, 32'hC}));

        // Decode table with an idle writeback port and an all-zero register file.
        for (int i = 0; i < NVEC; i++) begin
            v   = vecs[i];
            ins = v.instr;
            bus.InstrD   = v.instr;
            bus.PCD      = v.pcd;
            bus.PCPlus4D = v.pcd + 32'd4;
            #1;
            check({v.name, "_rsD"}, 256'(w_all_d), 256'({ins[19:15], ins[24:20]}));
            tick();
            check({v.name, "_ctrl"}, 256'({w_act_ctrl, bus.RdE, bus.Rs1E, bus.Rs2E}),
                  256'({v.ctrl, v.rd, ins[19:15], ins[24:20]}));
            if (v.chk_imm) check({v.name, "_imm"}, 256'(bus.ImmExtE), 256'(v.imm));
            check({v.name, "_pc"}, 256'({bus.PCE, bus.PCPlus4E}), 256'({v.pcd, v.pcd + 32'd4}));
            check({v.name, "_rd12"}, 256'({bus.RD1E, bus.RD2E}), 256'(0));
        end

        // Write-through to rs1 (x1 <= 0x1234 in the same cycle as the read).
        bus.InstrD    = 32'h002081B3;
        bus.RegWriteW = 1'b1;
        bus.RDW       = 5'd1;
        bus.ResultW   = 32'h1234;
        tick();
        check("wt_rs1", 256'({bus.RD1E, bus.RD2E}), 256'({32'h1234, 32'h0}));

        // Write to x0 is dropped; x1 now reads its stored value through rs2.
        bus.InstrD  = 32'h001001B3;
        bus.RDW     = 5'd0;
        bus.ResultW = 32'hFFFF;
        tick();
        check("x0_ignored", 256'({bus.RD1E, bus.RD2E}), 256'({32'h0, 32'h1234}));

        // Write-through to rs2.
        bus.InstrD  = 32'h002081B3;
        bus.RDW     = 5'd2;
        bus.ResultW = 32'h5555;
        tick();
        check("wt_rs2", 256'({bus.RD1E, bus.RD2E}), 256'({32'h1234, 32'h5555}));

        // Flush of a valid lw while x7 is written back.
        bus.InstrD  = 32'hFFF02283;
        bus.FlushE  = 1'b1;
        bus.RDW     = 5'd7;
        bus.ResultW = 32'hCAFE;
        tick();
        check("flush_lw", 256'(w_all_e), 256'(0));

        // Flushing an illegal instruction also clears IllegalE.
        bus.InstrD    = 32'h0000007F;
        bus.RegWriteW = 1'b0;
        tick();
        check("flush_illegal", 256'(w_all_e), 256'(0));

        // x7 was written during the flush: add x8,x7,x0.
        bus.FlushE = 1'b0;
        bus.InstrD = 32'h00038433;
        tick();
        check("x7_after_flush", 256'({bus.RD1E, bus.RD2E}), 256'({32'hCAFE, 32'h0}));
        check("x7_ctrl", 256'({w_act_ctrl, bus.RdE}), 256'({10'b1000_00_000_0, 5'd8}));

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        #2 rst = 1'b0;
        #1;
        check("async_reset_E", 256'(w_all_e), 256'(0));
        check("async_reset_D", 256'(w_all_d), 256'(0));
        #2 rst = 1'b1;
        bus.InstrD = 32'h002081B3;
        tick();
        check("regs_cleared", 256'({bus.RD1E, bus.RD2E}), 256'(0));
        check("after_reset_ctrl", 256'({w_act_ctrl, bus.RdE}), 256'({10'b1000_00_000_0, 5'd3}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
